alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter and sequencer for the shared 32-bit ALU in the image-convolution processor. It accepts operation requests from two masters, port 0 (control unit) and port 1 (convolution address/MAC engine). It grants one request at a time with round-robin priority, drives the ALU operand/control bus for a fixed latency, and returns the registered result with a zero flag to the granted port.

## Interface
- ALU_LAT, 2: cycles from the ALU enable cycle to the cycle in which the ALU result is sampled; legal 1..15.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  request level; sampled only while the FSM is IDLE.
- op0 / op1  in  4  ALU opcode: 1 ADD, 2 SUB, 3 MUL, 4 MOD, 5 PASSA, 6 PASSB, 7 INC, 8 DEC, 9 RESET.
- a0, b0 / a1, b1  in  32  operands.
- gnt0 / gnt1  out  1  high from ISSUE through DONE for the granted port.
- done0 / done1  out  1  one-cycle completion pulse.
- result0 / result1  out  32  per-port registered result; held until that port's next done.
- z0 / z1  out  1  per-port registered flag: result == 0.
- err0 / err1  out  1  per-port registered flag: opcode was illegal.
- alu_a, alu_b  out  32  ALU operand buses.
- alu_ctrl  out  4  ALU control.
- alu_en  out  1  ALU enable; one-cycle pulse per operation.
- alu_c  in  32  ALU result bus.
- busy  out  1  high whenever the FSM is not IDLE.

## Operation
- FSM states are IDLE, ISSUE, WAIT and DONE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant that port.
  - If both are high, grant the port not granted last. The last-grant pointer resets to "1", so port 0 wins the first tie.
  - On grant, latch op, a, b and the port ID, and update the pointer.
  - Legal opcode (1..9): go to ISSUE.
  - Illegal opcode (0 or 10..15): go directly to DONE with result 0 and err 1. The ALU is not touched.
- ISSUE:
  - Drive alu_a, alu_b and alu_ctrl from the latched values.
  - Assert alu_en for this cycle only.
  - Load the wait counter with ALU_LAT, then go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter equals 1, capture alu_c into the internal result register, then go to DONE.
- DONE:
  - Pulse done for the granted port.
  - Update that port's result, z and err; the other port's outputs are unchanged.
  - Go to IDLE.
- alu_a, alu_b and alu_ctrl hold their last issued values until the next ISSUE, so the ALU bus stays stable through WAIT.
- Operand or opcode changes on the request ports after the grant are ignored.
- A request still high during DONE is treated as a new request in the following IDLE cycle. Requesters deassert req on seeing done unless they intend back-to-back operations.
- z is computed on the full 32-bit result. No carry or overflow is reported; arithmetic wraps modulo 2^32 inside the ALU.

## Timing
- Cycle 0 is the IDLE cycle in which req is sampled high.
- Legal op: ISSUE in cycle 1 (alu_en = 1). WAIT in cycles 2..ALU_LAT+1. DONE in cycle ALU_LAT+2. For ALU_LAT = 2, done is in cycle 4.
- Illegal op: DONE in cycle 1.
- One operation occupies ALU_LAT+3 cycles including the IDLE cycle. With both ports requesting continuously, grants strictly alternate.
- Reset values: every output is 0 (gnt, done, result, z, err, alu_a, alu_b, alu_ctrl, alu_en, busy). State is IDLE and the pointer is 1.
- Reset asserted mid-operation:
  - All outputs clear immediately, without waiting for a clock edge.
  - The in-flight operation is dropped and no done is produced.
  - Any ALU output still pending is never captured.

## Test plan
- Single operation: req0 with ADD, a0 = 5, b0 = 7 → alu_en high in cycle 1 only; gnt0 high in cycles 1-4; done0 in cycle 4; result0 = 12, z0 = 0, err0 = 0.
- Simultaneous requests after reset: req0 with SUB 10, 10 and req1 with MUL 6, 7, both high → port 0 served first (done0 cycle 4, result0 = 0, z0 = 1). Port 1 is granted in cycle 5 with done1 in cycle 9, result1 = 42.
- Fairness: req0 and req1 held high for 40 cycles → grant sequence 0,1,0,1…; each port gets a done every 10 cycles.
- Illegal opcode: req1 with op1 = 4'hA → done1 in cycle 1, err1 = 1, result1 = 0, z1 = 1; alu_en never asserts.
- Reset mid-operation: rst_n low in cycle 2 of a port-0 ADD → all outputs are 0 before the next edge and no done0 follows. After release, a new req0 with INC a0 = 0xFFFFFFFF completes with result0 = 0, z0 = 1.
- Operand stability: a0 changed from 3 to 99 during WAIT of a PASSA → result0 = 3, and alu_a stays 3 until the next ISSUE.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bus bundle between the two ALU requesters, the shared ALU and the arbiter.
// The arbiter takes the slave view; the requesters and the ALU take the master view.
interface alu_arbiter_if;
  logic        req0, req1;
  logic [3:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1;
  logic        done0, done1;
  logic [31:0] result0, result1;
  logic        z0, z1;
  logic        err0, err1;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic        alu_en;
  logic [31:0] alu_c;
  logic        busy;

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, alu_c,
    output gnt0, gnt1, done0, done1, result0, result1, z0, z1, err0, err1,
           alu_a, alu_b, alu_ctrl, alu_en, busy
  );

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, alu_c,
    input  gnt0, gnt1, done0, done1, result0, result1, z0, z1, err0, err1,
           alu_a, alu_b, alu_ctrl, alu_en, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin two-port arbiter/sequencer for the shared ALU: grants one request,
// drives the ALU bus for ALU_LAT cycles and returns a registered result per port.
module alu_arbiter #(
  parameter int unsigned ALU_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state;
  logic        last;
  logic        port;
  logic [3:0]  cnt;

  logic        any_req, pick, legal, finish, fin_port, fin_err;
  logic [3:0]  sel_op;
  logic [31:0] sel_a, sel_b, fin_res;

  always_comb begin
    any_req = bus.req0 | bus.req1;
    pick    = (bus.req0 & bus.req1) ? ~last : bus.req1;
    sel_op  = pick ? bus.op1 : bus.op0;
    sel_a   = pick ? bus.a1  : bus.a0;
    sel_b   = pick ? bus.b1  : bus.b0;
    legal   = (sel_op >= 4'd1) && (sel_op <= 4'd9);
    // Two ways to complete: an illegal grant straight from IDLE, or the last WAIT cycle.
    finish   = ((state == IDLE) && any_req && !legal) || ((state == WAIT) && (cnt == 4'd1));
    fin_port = (state == IDLE) ? pick : port;
    fin_err  = (state == IDLE);
    fin_res  = (state == IDLE) ? 32'd0 : bus.alu_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= 1'b1;
      port        <= 1'b0;
      cnt         <= '0;
      bus.gnt0    <= 1'b0;
      bus.gnt1    <= 1'b0;
      bus.done0   <= 1'b0;
      bus.done1   <= 1'b0;
      bus.result0 <= '0;
      bus.result1 <= '0;
      bus.z0      <= 1'b0;
      bus.z1      <= 1'b0;
      bus.err0    <= 1'b0;
      bus.err1    <= 1'b0;
      bus.alu_a   <= '0;
      bus.alu_b   <= '0;
      bus.alu_ctrl<= '0;
      bus.alu_en  <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          port     <= pick;
          last     <= pick;
          bus.gnt0 <= ~pick;
          bus.gnt1 <= pick;
          bus.busy <= 1'b1;
          if (legal) begin
            // The ALU bus registers double as the operand latch and hold until the next issue.
            bus.alu_a    <= sel_a;
            bus.alu_b    <= sel_b;
            bus.alu_ctrl <= sel_op;
            bus.alu_en   <= 1'b1;
            state        <= ISSUE;
          end else begin
            state <= DONE;
          end
        end
        ISSUE: begin
          bus.alu_en <= 1'b0;
          cnt        <= 4'(ALU_LAT);
          state      <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= DONE;
        end
        DONE: begin
          bus.done0 <= 1'b0;
          bus.done1 <= 1'b0;
          bus.gnt0  <= 1'b0;
          bus.gnt1  <= 1'b0;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (finish) begin
        if (fin_port) begin
          bus.done1   <= 1'b1;
          bus.result1 <= fin_res;
          bus.z1      <= (fin_res == 32'd0);
          bus.err1    <= fin_err;
        end else begin
          bus.done0   <= 1'b1;
          bus.result0 <= fin_res;
          bus.z0      <= (fin_res == 32'd0);
          bus.err0    <= fin_err;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand sequences for
// arbitration/reset/stability, and randomized traffic against a transaction model.
module tb_alu_arbiter;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if bus();
  alu_arbiter #(.ALU_LAT(LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd1: return a + b;
      4'd2: return a - b;
      4'd3: return a * b;
      4'd4: return (b == 0) ? 32'd0 : a % b;
      4'd5: return a;
      4'd6: return b;
      4'd7: return a + 32'd1;
      4'd8: return a - 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural shared ALU sitting on the bus.
  assign bus.alu_c = alu_ref(bus.alu_ctrl, bus.alu_a, bus.alu_b);

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_in();
    bus.req0 = 0; bus.req1 = 0; bus.op0 = 0; bus.op1 = 0;
    bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_flags"}, {22'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.z0, bus.z1,
                         bus.err0, bus.err1, bus.alu_en, bus.busy}, 32'd0);
    chk({nm, "_result0"}, bus.result0, 32'd0);
    chk({nm, "_result1"}, bus.result1, 32'd0);
    chk({nm, "_alu_a"}, bus.alu_a, 32'd0);
    chk({nm, "_alu_b"}, bus.alu_b, 32'd0);
    chk({nm, "_alu_ctrl"}, {28'd0, bus.alu_ctrl}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    clear_in();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  typedef struct {
    logic        port;
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic        z, err;
    int          lat;
  } vec_t;

  task automatic run_op(input vec_t v, input string nm);
    int cyc, en;
    logic got;
    wait_idle();
    if (v.port) begin bus.req1 = 1; bus.op1 = v.op; bus.a1 = v.a; bus.b1 = v.b; end
    else        begin bus.req0 = 1; bus.op0 = v.op; bus.a0 = v.a; bus.b0 = v.b; end
    @(posedge clk); #1;
    bus.req0 = 0; bus.req1 = 0;
    cyc = 1; en = 0; got = 0;
    while (cyc < 30) begin
      if (bus.alu_en) en++;
      got = v.port ? bus.done1 : bus.done0;
      if (got) break;
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, "_done_cycle"}, cyc, v.lat);
    chk({nm, "_result"}, v.port ? bus.result1 : bus.result0, v.res);
    chk({nm, "_z"}, {31'd0, v.port ? bus.z1 : bus.z0}, {31'd0, v.z});
    chk({nm, "_err"}, {31'd0, v.port ? bus.err1 : bus.err0}, {31'd0, v.err});
    chk({nm, "_alu_en_count"}, en, v.err ? 0 : 1);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b0, 4'd1,  32'd5,          32'd7,       32'd12,         1'b0, 1'b0, 4};
    vecs[1]  = '{1'b1, 4'd2,  32'd10,         32'd10,      32'd0,          1'b1, 1'b0, 4};
    vecs[2]  = '{1'b0, 4'd3,  32'd6,          32'd7,       32'd42,         1'b0, 1'b0, 4};
    vecs[3]  = '{1'b1, 4'd4,  32'd17,         32'd5,       32'd2,          1'b0, 1'b0, 4};
    vecs[4]  = '{1'b0, 4'd5,  32'd3,          32'd9,       32'd3,          1'b0, 1'b0, 4};
    vecs[5]  = '{1'b1, 4'd6,  32'd3,          32'd9,       32'd9,          1'b0, 1'b0, 4};
    vecs[6]  = '{1'b0, 4'd7,  32'hFFFF_FFFF,  32'd0,       32'd0,          1'b1, 1'b0, 4};
    vecs[7]  = '{1'b1, 4'd8,  32'd0,          32'd0,       32'hFFFF_FFFF,  1'b0, 1'b0, 4};
    vecs[8]  = '{1'b0, 4'd9,  32'd1234,       32'd5678,    32'd0,          1'b1, 1'b0, 4};
    vecs[9]  = '{1'b1, 4'hA,  32'd1,          32'd2,       32'd0,          1'b1, 1'b1, 1};
    vecs[10] = '{1'b0, 4'h0,  32'd1,          32'd2,       32'd0,          1'b1, 1'b1, 1};
    vecs[11] = '{1'b1, 4'd3,  32'h0001_0000,  32'h0001_0000, 32'd0,        1'b1, 1'b0, 4};

    clear_in();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 12; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Tie after reset: port 0 first, port 1 sampled in the following IDLE.
    begin
      int c0, c1;
      logic g1_at6;
      do_reset();
      bus.req0 = 1; bus.op0 = 4'd2; bus.a0 = 10; bus.b0 = 10;
      bus.req1 = 1; bus.op1 = 4'd3; bus.a1 = 6;  bus.b1 = 7;
      c0 = -1; c1 = -1; g1_at6 = 0;
      for (int c = 1; c <= 14; c++) begin
        @(posedge clk); #1;
        if (c == 6) g1_at6 = bus.gnt1;
        if (bus.done0 && c0 < 0) begin
          c0 = c; bus.req0 = 0;
          chk("tie_result0", bus.result0, 32'd0);
          chk("tie_z0", {31'd0, bus.z0}, 32'd1);
        end
        if (bus.done1 && c1 < 0) begin
          c1 = c; bus.req1 = 0;
          chk("tie_result1", bus.result1, 32'd42);
        end
      end
      chk("tie_done0_cycle", c0, 4);
      chk("tie_done1_cycle", c1, 9);
      chk("tie_gnt1_cycle6", {31'd0, g1_at6}, 32'd1);
    end

    // Fairness: both held for 40 cycles.
    begin
      int k;
      do_reset();
      bus.req0 = 1; bus.op0 = 4'd1; bus.a0 = 1; bus.b0 = 1;
      bus.req1 = 1; bus.op1 = 4'd2; bus.a1 = 5; bus.b1 = 1;
      k = 0;
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk); #1;
        if (bus.done0 || bus.done1) begin
          chk($sformatf("fair_port%0d", k), {31'd0, bus.done1}, k % 2);
          chk($sformatf("fair_cycle%0d", k), c, 4 + 5 * k);
          k++;
        end
      end
      clear_in();
      chk("fair_done_count", k, 8);
    end

    // Reset in cycle 2 of an ADD.
    begin
      int nd;
      wait_idle();
      bus.req0 = 1; bus.op0 = 4'd1; bus.a0 = 5; bus.b0 = 7;
      @(posedge clk); #1;
      bus.req0 = 0;
      @(posedge clk); #3;
      rst_n = 0;
      #1;
      chk_all_zero("midrst");
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      nd = 0;
      for (int c = 0; c < 8; c++) begin
        @(posedge clk); #1;
        if (bus.done0 || bus.done1) nd++;
      end
      chk("midrst_no_done", nd, 0);
      run_op(vecs[6], "postrst_inc");
    end

    // Operand change during WAIT must not leak into result or ALU bus.
    begin
      int c;
      wait_idle();
      bus.req0 = 1; bus.op0 = 4'd5; bus.a0 = 3; bus.b0 = 0;
      @(posedge clk); #1;
      bus.req0 = 0;
      @(posedge clk); #1;
      bus.a0 = 99;
      c = 0;
      while (!bus.done0 && c < 20) begin @(posedge clk); #1; c++; end
      chk("stab_done_seen", {31'd0, bus.done0}, 32'd1);
      chk("stab_result0", bus.result0, 32'd3);
      repeat (3) @(posedge clk);
      #1;
      chk("stab_alu_a_hold", bus.alu_a, 32'd3);
      clear_in();
    end

    // Random traffic against a transaction-level model.
    begin
      int gf, de, ee, ns;
      logic last, p;
      logic [31:0] er;
      logic ee_err;
      logic r0, r1;
      logic [3:0] o0, o1;
      logic [31:0] x0, y0, x1, y1;
      do_reset();
      gf = -10; de = -10; ee = -10; ns = 0; last = 1; p = 0; er = 0; ee_err = 0;
      for (int e = 0; e < 600; e++) begin
        @(negedge clk);
        r0 = ($urandom_range(0, 2) != 0);
        r1 = ($urandom_range(0, 2) != 0);
        o0 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 16) % 16) : 4'($urandom_range(1, 9));
        o1 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 16) % 16) : 4'($urandom_range(1, 9));
        x0 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 20);
        y0 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 20);
        x1 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 20);
        y1 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 20);
        bus.req0 = r0; bus.op0 = o0; bus.a0 = x0; bus.b0 = y0;
        bus.req1 = r1; bus.op1 = o1; bus.a1 = x1; bus.b1 = y1;
        @(posedge clk);
        if (e >= ns && (r0 || r1)) begin
          logic [3:0] o;
          logic lg;
          p = (r0 && r1) ? ~last : r1;
          last = p;
          o = p ? o1 : o0;
          lg = (o >= 1 && o <= 9);
          gf = e;
          de = e + (lg ? LAT + 1 : 0);
          ee = lg ? e : -10;
          er = lg ? (p ? alu_ref(o1, x1, y1) : alu_ref(o0, x0, y0)) : 32'd0;
          ee_err = !lg;
          ns = de + 2;
        end
        #1;
        begin
          logic b;
          b = (e >= gf && e <= de);
          chk("rnd_busy", {31'd0, bus.busy}, {31'd0, b});
          chk("rnd_gnt0", {31'd0, bus.gnt0}, {31'd0, b && !p});
          chk("rnd_gnt1", {31'd0, bus.gnt1}, {31'd0, b && p});
          chk("rnd_alu_en", {31'd0, bus.alu_en}, {31'd0, e == ee});
          chk("rnd_done0", {31'd0, bus.done0}, {31'd0, e == de && !p});
          chk("rnd_done1", {31'd0, bus.done1}, {31'd0, e == de && p});
          if (e == de) begin
            chk("rnd_result", p ? bus.result1 : bus.result0, er);
            chk("rnd_z", {31'd0, p ? bus.z1 : bus.z0}, {31'd0, er == 0});
            chk("rnd_err", {31'd0, p ? bus.err1 : bus.err0}, {31'd0, ee_err});
          end
        end
      end
      clear_in();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
